// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU issue path: ALU control encodings (also used
// by the ALU itself), RV32I major opcodes, and the issued-beat record that
// travels from the decoder through the skid buffer to the EX stage.
package alu_pkg;

  // Datapath width of issue_beat_t; alu_issue_stage's XLEN must match it.
  localparam int ALU_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [ALU_XLEN-1:0] x;
    logic [ALU_XLEN-1:0] y;
    alu_op_e             ctrl;
    logic                illegal;
  } issue_beat_t;

  // All-zero beat: ADD, x=y=0, legal. Used as the register reset value.
  localparam issue_beat_t BEAT_RESET = '{x: '0, y: '0, ctrl: ALU_ADD, illegal: 1'b0};

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode
// Purely combinational decode of RV32I instruction fields into an issue beat
// (ALU operands, ALU control code, illegal flag).
// Ports:
//   in_opcode/in_funct3/in_funct7 : instruction fields
//   in_pc, in_rs1_data, in_rs2_data, in_imm : operand sources
//   beat : decoded issue_beat_t
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [6:0]          in_opcode,
  input  logic [2:0]          in_funct3,
  input  logic [6:0]          in_funct7,
  input  logic [ALU_XLEN-1:0] in_pc,
  input  logic [ALU_XLEN-1:0] in_rs1_data,
  input  logic [ALU_XLEN-1:0] in_rs2_data,
  input  logic [ALU_XLEN-1:0] in_imm,
  output issue_beat_t         beat
);

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [ALU_XLEN-1:0] x;
  logic [ALU_XLEN-1:0] y;
  alu_op_e             ctrl;
  logic                illegal;

  always_comb begin
    x       = '0;
    y       = '0;
    ctrl    = ALU_ADD;
    illegal = 1'b0;
    unique case (in_opcode)
      OPC_OP: begin
        x    = in_rs1_data;
        y    = in_rs2_data;
        ctrl = alu_op_e'({in_funct7[5], in_funct3});
        if (in_funct7 == F7_ALT) begin
          // Only SUB and SRA use the alternate funct7 encoding.
          illegal = !((in_funct3 == 3'b000) || (in_funct3 == 3'b101));
        end else begin
          illegal = (in_funct7 != F7_ZERO);
        end
      end
      OPC_OPIMM: begin
        x    = in_rs1_data;
        y    = in_imm;
        // Only the right-shift immediate uses funct7[5] (SRLI/SRAI); other
        // funct3 values reuse immediate bits there and must not leak into ctrl.
        ctrl = alu_op_e'({(in_funct3 == 3'b101) ? in_funct7[5] : 1'b0, in_funct3});
        if (in_funct3 == 3'b001) begin
          illegal = (in_funct7 != F7_ZERO);
        end else if (in_funct3 == 3'b101) begin
          illegal = (in_funct7 != F7_ZERO) && (in_funct7 != F7_ALT);
        end
      end
      OPC_LUI: begin
        y = in_imm;
      end
      OPC_AUIPC: begin
        x = in_pc;
        y = in_imm;
      end
      OPC_LOAD, OPC_STORE: begin
        x = in_rs1_data;
        y = in_imm;
      end
      OPC_BRANCH: begin
        x = in_rs1_data;
        y = in_rs2_data;
        unique case (in_funct3[2:1])
          2'b00:   ctrl = ALU_SUB;
          2'b10:   ctrl = ALU_SLT;
          2'b11:   ctrl = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        x = in_pc;
        y = ALU_XLEN'(4);
      end
      default: illegal = 1'b1;
    endcase

    // Illegal beats are issued as a harmless ADD of zeros.
    if (illegal) begin
      x    = '0;
      y    = '0;
      ctrl = ALU_ADD;
    end
  end

  assign beat = '{x: x, y: y, ctrl: ctrl, illegal: illegal};

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// ID->EX issue stage: decodes incoming fields into ALU operands/control and
// registers them into a 2-entry skid buffer (main + skid). Outputs come
// straight from the main register; in_ready depends only on the skid valid
// flop (and reset), never on out_ready.
// Ports:
//   clk, rst (async, active-high), flush (sync, highest priority)
//   in_valid/in_ready + instruction fields and operands (upstream)
//   out_valid/out_ready + out_x, out_y, out_alu_ctrl, out_illegal (to EX)
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_x,
  output logic [XLEN-1:0] out_y,
  output logic [3:0]      out_alu_ctrl,
  output logic            out_illegal
);

  issue_beat_t dec_beat;
  issue_beat_t main_q, main_d;
  issue_beat_t skid_q, skid_d;
  logic        main_valid_q, main_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        accept;
  logic        drain;

  alu_op_decode u_decode (
    .in_opcode   (in_opcode),
    .in_funct3   (in_funct3),
    .in_funct7   (in_funct7),
    .in_pc       (in_pc),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .in_imm      (in_imm),
    .beat        (dec_beat)
  );

  assign in_ready = !rst && !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign drain    = main_valid_q && out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      // Data registers keep their contents; only the valid bits drop.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain) begin
      if (skid_valid_q) begin
        // in_ready is low while skid is full, so no accept can coincide here.
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d = dec_beat;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_d       = dec_beat;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = dec_beat;
        main_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= BEAT_RESET;
      skid_q       <= BEAT_RESET;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid    = main_valid_q;
  assign out_x        = main_q.x;
  assign out_y        = main_q.y;
  assign out_alu_ctrl = main_q.ctrl;
  assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [6:0]      in_opcode = '0;
  logic [2:0]      in_funct3 = '0;
  logic [6:0]      in_funct7 = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic [XLEN-1:0] in_rs1_data = '0;
  logic [XLEN-1:0] in_rs2_data = '0;
  logic [XLEN-1:0] in_imm = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] out_x;
  logic [XLEN-1:0] out_y;
  logic [3:0]      out_alu_ctrl;
  logic            out_illegal;

  int checks = 0;
  int failures = 0;

  alu_issue_stage #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_funct3    (in_funct3),
    .in_funct7    (in_funct7),
    .in_pc        (in_pc),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .in_imm       (in_imm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_x        (out_x),
    .out_y        (out_y),
    .out_alu_ctrl (out_alu_ctrl),
    .out_illegal  (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm);
    in_valid    = 1'b1;
    in_opcode   = opc;
    in_funct3   = f3;
    in_funct7   = f7;
    in_pc       = pc;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
    in_imm      = imm;
  endtask

  // One beat with out_ready high; checks the beat on the outputs one cycle later.
  task automatic issue_one(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] pc, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [31:0] imm,
                           input logic [3:0] exp_ctrl, input logic [31:0] exp_x,
                           input logic [31:0] exp_y, input logic exp_ill);
    drive(opc, f3, f7, pc, rs1, rs2, imm);
    tick();
    in_valid = 1'b0;
    check_eq({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check_eq({tag, "_ctrl"}, {28'b0, out_alu_ctrl}, {28'b0, exp_ctrl});
    check_eq({tag, "_x"}, out_x, exp_x);
    check_eq({tag, "_y"}, out_y, exp_y);
    check_eq({tag, "_ill"}, {31'b0, out_illegal}, {31'b0, exp_ill});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    check_eq("rst_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_x", out_x, 32'd0);
    check_eq("rst_y", out_y, 32'd0);
    check_eq("rst_ctrl", {28'b0, out_alu_ctrl}, 32'd0);
    check_eq("rst_ill", {31'b0, out_illegal}, 32'd0);
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    tick();

    // Decode vectors, out_ready high
    issue_one("op_sub",   7'b0110011, 3'b000, 7'b0100000, 32'h0, 32'd10, 32'd3, 32'h0,
              4'b1000, 32'd10, 32'd3, 1'b0);
    issue_one("op_sra",   7'b0110011, 3'b101, 7'b0100000, 32'h0, 32'hF0, 32'h4, 32'h0,
              4'b1101, 32'hF0, 32'h4, 1'b0);
    issue_one("op_bad",   7'b0110011, 3'b001, 7'b0100000, 32'h0, 32'h5, 32'h6, 32'h0,
              4'b0000, 32'h0, 32'h0, 1'b1);
    issue_one("srai",     7'b0010011, 3'b101, 7'b0100000, 32'h0, 32'h80000000, 32'h0, 32'h404,
              4'b1101, 32'h80000000, 32'h404, 1'b0);
    issue_one("slli_bad", 7'b0010011, 3'b001, 7'b0100000, 32'h0, 32'h80000000, 32'h0, 32'h404,
              4'b0000, 32'h0, 32'h0, 1'b1);
    issue_one("xori",     7'b0010011, 3'b100, 7'b0100000, 32'h0, 32'h12, 32'h0, 32'h7FF,
              4'b0100, 32'h12, 32'h7FF, 1'b0);
    issue_one("auipc",    7'b0010111, 3'b000, 7'b0000000, 32'h1000, 32'h9, 32'h9, 32'h2000,
              4'b0000, 32'h1000, 32'h2000, 1'b0);
    issue_one("lui",      7'b0110111, 3'b000, 7'b0000000, 32'h1000, 32'h9, 32'h9, 32'h5000,
              4'b0000, 32'h0, 32'h5000, 1'b0);
    issue_one("jalr",     7'b1100111, 3'b000, 7'b0000000, 32'h40, 32'h77, 32'h0, 32'h8,
              4'b0000, 32'h40, 32'h4, 1'b0);
    issue_one("bltu",     7'b1100011, 3'b110, 7'b0000000, 32'h0, 32'h21, 32'h22, 32'h10,
              4'b0011, 32'h21, 32'h22, 1'b0);
    issue_one("br_bad",   7'b1100011, 3'b010, 7'b0000000, 32'h0, 32'h21, 32'h22, 32'h10,
              4'b0000, 32'h0, 32'h0, 1'b1);
    issue_one("system",   7'b1110011, 3'b000, 7'b0000000, 32'h0, 32'h1, 32'h2, 32'h3,
              4'b0000, 32'h0, 32'h0, 1'b1);
    tick();
    check_eq("drain_idle_valid", {31'b0, out_valid}, 32'd0);

    // Backpressure: A -> main, B -> skid, C blocked
    out_ready = 1'b0;
    drive(7'b0110011, 3'b000, 7'b0000000, 32'h0, 32'h11, 32'h1, 32'h0);
    tick();
    drive(7'b0110011, 3'b000, 7'b0000000, 32'h0, 32'h22, 32'h2, 32'h0);
    tick();
    check_eq("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
    check_eq("bp_a_x", out_x, 32'h11);
    drive(7'b0110011, 3'b000, 7'b0000000, 32'h0, 32'h33, 32'h3, 32'h0);
    tick();
    check_eq("bp_a_hold_x", out_x, 32'h11);
    check_eq("bp_a_hold_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    check_eq("bp_b_x", out_x, 32'h22);
    check_eq("bp_in_ready_free", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("bp_c_x", out_x, 32'h33);
    check_eq("bp_c_valid", {31'b0, out_valid}, 32'd1);
    tick();
    check_eq("bp_no_dup_valid", {31'b0, out_valid}, 32'd0);

    // Flush with main+skid full and a beat presented
    out_ready = 1'b0;
    drive(7'b0110011, 3'b000, 7'b0000000, 32'h0, 32'h44, 32'h1, 32'h0);
    tick();
    drive(7'b0110011, 3'b000, 7'b0000000, 32'h0, 32'h55, 32'h1, 32'h0);
    tick();
    check_eq("fl_full_in_ready", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    drive(7'b0110011, 3'b000, 7'b0000000, 32'h0, 32'h66, 32'h1, 32'h0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check_eq("fl_valid", {31'b0, out_valid}, 32'd0);
    check_eq("fl_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("fl_data_kept", out_x, 32'h44);
    tick();
    check_eq("fl_skid_dropped", {31'b0, out_valid}, 32'd0);

    // Flush with in_ready high: beat must still be dropped
    drive(7'b0110011, 3'b000, 7'b0000000, 32'h0, 32'h77, 32'h1, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check_eq("fl_rdy_dropped", {31'b0, out_valid}, 32'd0);

    // Async reset with main+skid full
    drive(7'b0110011, 3'b000, 7'b0000000, 32'h0, 32'h88, 32'h8, 32'h0);
    tick();
    drive(7'b0110011, 3'b000, 7'b0000000, 32'h0, 32'h99, 32'h9, 32'h0);
    tick();
    in_valid = 1'b0;
    check_eq("ar_pre_valid", {31'b0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("ar_valid", {31'b0, out_valid}, 32'd0);
    check_eq("ar_x", out_x, 32'd0);
    check_eq("ar_y", out_y, 32'd0);
    check_eq("ar_in_ready", {31'b0, in_ready}, 32'd0);
    #3 rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check_eq("ar_skid_lost", {31'b0, out_valid}, 32'd0);
    issue_one("ar_next", 7'b0110011, 3'b111, 7'b0000000, 32'h0, 32'hAA, 32'h0F, 32'h0,
              4'b0111, 32'hAA, 32'h0F, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
